// File: rtl/usb_ft245_fifo_bridge.sv
// FT245 USB FIFO chip <-> register-controller byte bridge: RX/TX FIFOs plus an RD#/WR# pin-timing FSM.
// Latency: popped RX byte is registered (valid the cycle after rx_req); chip bytes enter the RX FIFO at the end of RD#.
// Backpressure: tx_full at DEPTH-1, pushes beyond DEPTH drop; chip reads stall while the RX FIFO is full.

module usb_ft245_fifo_bridge_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

module usb_ft245_fifo_bridge #(
    parameter int FIFO_AW  = 4,
    parameter int RD_PULSE = 4,
    parameter int WR_PULSE = 4,
    parameter int RECOV    = 3,
    parameter int SETUP    = 1
) (
    input  logic       I_sys_clk,
    input  logic       I_sys_rst_n,
    input  logic       I_ft_rxf_n,
    input  logic       I_ft_txe_n,
    output logic       O_ft_rd_n,
    output logic       O_ft_wr_n,
    input  logic [7:0] I_ft_data,
    output logic [7:0] O_ft_data,
    output logic       O_ft_data_oe,
    input  logic       I_usb_uart_rx_req,
    output logic [7:0] O_usb_uart_rx_data,
    output logic       O_usb_uart_rx_empty,
    input  logic       I_usb_uart_tx_req,
    input  logic [7:0] I_usb_uart_tx_data,
    output logic       O_usb_uart_tx_full,
    output logic       O_rx_underrun,
    output logic       O_tx_drop
);
    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   TX_ALMOST  = (FIFO_AW+1)'(DEPTH - 1);
    // Phase counter is 4 bits, so every timing parameter must be 1..15.
    localparam logic [3:0]         RD_LAST    = 4'(RD_PULSE - 1);
    localparam logic [3:0]         WR_LAST    = 4'(WR_PULSE - 1);
    localparam logic [3:0]         RECOV_LAST = 4'(RECOV - 1);
    localparam logic [3:0]         SETUP_LAST = 4'(SETUP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_LOW, S_RD_RECOV, S_WR_SETUP, S_WR_LOW, S_WR_RECOV
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       phase_q, phase_d;
    logic             last_wr_q, last_wr_d;
    logic [7:0]       ft_data_q;
    logic             rxf_meta_q, rxf_sync_q, txe_meta_q, txe_sync_q;
    logic [7:0]       rx_data_q;
    logic             rx_underrun_q, tx_drop_q;

    logic             rd_n, wr_n, oe, rx_push, tx_pop;
    logic             rd_ok, wr_ok, rx_pop;
    logic [7:0]       rx_head, tx_head;
    logic [FIFO_AW:0] rx_count, tx_count;
    logic             rx_full, rx_fifo_empty, tx_full_true, tx_empty;

    usb_ft245_fifo_bridge_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
        .clk_i      (I_sys_clk),
        .rst_n_i    (I_sys_rst_n),
        .push_i     (rx_push),
        .push_dat_i (I_ft_data),
        .pop_i      (rx_pop),
        .head_dat_o (rx_head),
        .count_o    (rx_count),
        .full_o     (rx_full),
        .empty_o    (rx_fifo_empty)
    );

    usb_ft245_fifo_bridge_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
        .clk_i      (I_sys_clk),
        .rst_n_i    (I_sys_rst_n),
        .push_i     (I_usb_uart_tx_req),
        .push_dat_i (I_usb_uart_tx_data),
        .pop_i      (tx_pop),
        .head_dat_o (tx_head),
        .count_o    (tx_count),
        .full_o     (tx_full_true),
        .empty_o    (tx_empty)
    );

    assign rx_pop = I_usb_uart_rx_req && !rx_fifo_empty;

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            rxf_meta_q    <= 1'b1;
            rxf_sync_q    <= 1'b1;
            txe_meta_q    <= 1'b1;
            txe_sync_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_underrun_q <= 1'b0;
            tx_drop_q     <= 1'b0;
        end else begin
            rxf_meta_q    <= I_ft_rxf_n;
            rxf_sync_q    <= rxf_meta_q;
            txe_meta_q    <= I_ft_txe_n;
            txe_sync_q    <= txe_meta_q;
            if (rx_pop) begin
                rx_data_q <= rx_head;
            end
            rx_underrun_q <= I_usb_uart_rx_req && rx_fifo_empty;
            tx_drop_q     <= I_usb_uart_tx_req && tx_full_true;
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            last_wr_q <= 1'b1;
            ft_data_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            last_wr_q <= last_wr_d;
            if (tx_pop) begin
                ft_data_q <= tx_head;
            end
        end
    end

    assign rd_ok = !rxf_sync_q && !rx_full;
    assign wr_ok = !txe_sync_q && !tx_empty;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        last_wr_d = last_wr_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                // Contention goes to whichever direction was not served last.
                if (rd_ok && (!wr_ok || last_wr_q)) begin
                    state_d   = S_RD_LOW;
                    last_wr_d = 1'b0;
                end else if (wr_ok) begin
                    state_d   = S_WR_SETUP;
                    last_wr_d = 1'b1;
                end
            end
            S_RD_LOW: begin
                if (phase_q == RD_LAST) begin
                    state_d = S_RD_RECOV;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_WR_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_d = S_WR_LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_WR_LOW: begin
                if (phase_q == WR_LAST) begin
                    state_d = S_WR_RECOV;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_RD_RECOV, S_WR_RECOV: begin
                if (phase_q == RECOV_LAST) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        oe      = 1'b0;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        case (state_q)
            S_IDLE:     tx_pop = (state_d == S_WR_SETUP);
            S_RD_LOW: begin
                rd_n    = 1'b0;
                rx_push = (phase_q == RD_LAST);
            end
            S_WR_SETUP: oe = 1'b1;
            S_WR_LOW: begin
                oe   = 1'b1;
                wr_n = 1'b0;
            end
            // Data stays driven one cycle past WR# rising for hold time.
            S_WR_RECOV: oe = (phase_q == 4'd0);
            default:    oe = 1'b0;
        endcase
    end

    assign O_ft_rd_n           = rd_n;
    assign O_ft_wr_n           = wr_n;
    assign O_ft_data_oe        = oe;
    assign O_ft_data           = ft_data_q;
    assign O_usb_uart_rx_data  = rx_data_q;
    assign O_usb_uart_rx_empty = (rx_count == '0);
    assign O_usb_uart_tx_full  = (tx_count >= TX_ALMOST);
    assign O_rx_underrun       = rx_underrun_q;
    assign O_tx_drop           = tx_drop_q;
endmodule

// File: tb/tb_usb_ft245_fifo_bridge.sv
// Bench for usb_ft245_fifo_bridge: FT245 chip model plus queue-based reference of byte order and pin timing.
module tb_usb_ft245_fifo_bridge;
    logic       clk;
    logic       rst_n;
    logic       ft_rxf_n, ft_txe_n, rd_n, wr_n, oe;
    logic [7:0] ft_din, ft_dout;
    logic       rx_req, tx_req, rx_empty, tx_full, rx_underrun, tx_drop;
    logic [7:0] rx_data, tx_data;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] chip_src [0:511];
    int         chip_wr;
    int         chip_rd;
    int         rd_len_q[$];
    int         rd_gap_q[$];
    int         wr_len_q[$];
    int         dir_q[$];
    logic [7:0] tx_cap_q[$];
    bit         oe_pre_q[$];
    bit         oe_post_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] last_rx;

    usb_ft245_fifo_bridge dut (
        .I_sys_clk           (clk),
        .I_sys_rst_n         (rst_n),
        .I_ft_rxf_n          (ft_rxf_n),
        .I_ft_txe_n          (ft_txe_n),
        .O_ft_rd_n           (rd_n),
        .O_ft_wr_n           (wr_n),
        .I_ft_data           (ft_din),
        .O_ft_data           (ft_dout),
        .O_ft_data_oe        (oe),
        .I_usb_uart_rx_req   (rx_req),
        .O_usb_uart_rx_data  (rx_data),
        .O_usb_uart_rx_empty (rx_empty),
        .I_usb_uart_tx_req   (tx_req),
        .I_usb_uart_tx_data  (tx_data),
        .O_usb_uart_tx_full  (tx_full),
        .O_rx_underrun       (rx_underrun),
        .O_tx_drop           (tx_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

    // Chip model: samples pins just after each rising edge, serves RX bytes, captures TX bytes.
    initial begin
        bit p_rd, p_wr, p_oe, p2_oe, post_pend, post_first, seen_rd;
        int rd_low, rd_high, wr_low;
        chip_rd = 0; ft_rxf_n = 1'b1; ft_din = 8'h00;
        p_rd = 1; p_wr = 1; p_oe = 0; p2_oe = 0; post_pend = 0; post_first = 0; seen_rd = 0;
        rd_low = 0; rd_high = 0; wr_low = 0;
        forever begin
            @(posedge clk);
            #1;
            if (post_pend) begin
                oe_post_q.push_back(post_first && (oe === 1'b0));
                post_pend = 0;
            end
            if (rd_n === 1'b0) begin
                if (p_rd) begin
                    if (seen_rd) rd_gap_q.push_back(rd_high);
                    rd_low = 0;
                end
                rd_low++;
                ft_din = chip_src[chip_rd[8:0]];
            end else begin
                if (!p_rd) begin
                    rd_len_q.push_back(rd_low);
                    if (chip_rd < chip_wr) chip_rd++;
                    dir_q.push_back(1);
                    seen_rd = 1;
                    rd_high = 0;
                end
                rd_high++;
            end
            if (wr_n === 1'b0) begin
                if (p_wr) begin
                    oe_pre_q.push_back(p_oe && !p2_oe);
                    wr_low = 0;
                end
                wr_low++;
            end else if (!p_wr) begin
                wr_len_q.push_back(wr_low);
                tx_cap_q.push_back(ft_dout);
                dir_q.push_back(2);
                post_first = (oe === 1'b1);
                post_pend  = 1;
            end
            p_rd     = (rd_n !== 1'b0);
            p_wr     = (wr_n !== 1'b0);
            p2_oe    = p_oe;
            p_oe     = (oe === 1'b1);
            ft_rxf_n = (chip_rd >= chip_wr) ? 1'b1 : 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        chip_src[chip_wr[8:0]] = b;
        chip_wr++;
        exp_rx.push_back(b);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_req  = 1'b1;
        tx_data = b;
        tick();
        tx_req  = 1'b0;
        exp_tx.push_back(b);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 200 && rx_empty !== 1'b0; i++) tick();
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'h00;
        check(tag, rx_data, e);
        last_rx = e;
    endtask

    task automatic wait_caps(input int cap0, input int n, input string tag);
        for (int i = 0; i < 60 * n + 60 && tx_cap_q.size() - cap0 < n; i++) tick();
        repeat (2) tick();
        check(tag, tx_cap_q.size() - cap0, n);
    endtask

    task automatic check_caps(input int cap0, input int n, input string tag);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
            check(tag, (cap0 + k < tx_cap_q.size()) ? {24'd0, tx_cap_q[cap0 + k]} : 32'hDEAD, {24'd0, e});
        end
    endtask

    initial begin
        int rd0, cap0, wl0, pre0, post0, d0, bad;
        logic [7:0] b;
        rst_n = 1'b0; ft_txe_n = 1'b1; rx_req = 1'b0; tx_req = 1'b0; tx_data = 8'h00;
        chip_wr = 0; last_rx = 8'h00;
        repeat (3) tick();

        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_oe", oe, 0);
        check("rst_ft_data", ft_dout, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_underrun", rx_underrun, 0);
        check("rst_drop", tx_drop, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // RX burst: fixed bytes, then a random burst popped with random spacing
        send_rx(8'h00); send_rx(8'hFF); send_rx(8'h02);
        for (int i = 0; i < 200 && chip_rd < chip_wr; i++) tick();
        tick();
        check("t1_reads", chip_rd, chip_wr);
        for (int k = 0; k < 3; k++) pop_check("t1_rx_data");
        check("t1_empty", rx_empty, 1);
        for (int k = 0; k < 3; k++)
            check("t1_rd_len", (k < rd_len_q.size()) ? rd_len_q[k] : -1, 4);
        for (int k = 0; k < 2; k++)
            check("t1_rd_gap_ge3", (k < rd_gap_q.size()) ? 32'(rd_gap_q[k] >= 3) : 0, 1);
        for (int k = 0; k < 6; k++) send_rx(8'($urandom_range(0, 255)));
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 6)) tick();
            pop_check("t1_rand_rx");
        end

        // RX full: 18 bytes offered, only 16 fit
        rd0 = chip_rd;
        send_rx(8'h00);
        for (int k = 0; k < 17; k++) send_rx(8'($urandom_range(0, 255)));
        for (int i = 0; i < 400 && chip_rd - rd0 < 16; i++) tick();
        repeat (40) tick();
        check("t2_reads_at_full", chip_rd - rd0, 16);
        check("t2_rd_idle", rd_n, 1);
        check("t2_not_empty", rx_empty, 0);
        pop_check("t2_first_pop");
        repeat (40) tick();
        check("t2_one_more_read", chip_rd - rd0, 17);
        for (int k = 0; k < 17; k++) pop_check("t2_drain");
        check("t2_drained", rx_empty, 1);

        // TX path: 0x55 x3 back to back, then random bytes
        ft_txe_n = 1'b0;
        cap0 = tx_cap_q.size(); wl0 = wr_len_q.size(); pre0 = oe_pre_q.size(); post0 = oe_post_q.size();
        tx_req = 1'b1; tx_data = 8'h55;
        repeat (3) tick();
        tx_req = 1'b0;
        repeat (3) exp_tx.push_back(8'h55);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 8)) tick();
            push_tx(8'($urandom_range(0, 255)));
        end
        wait_caps(cap0, 7, "t3_capture_count");
        check_caps(cap0, 7, "t3_tx_byte");
        for (int k = 0; k < 7; k++) begin
            check("t3_wr_len", (wl0 + k < wr_len_q.size()) ? wr_len_q[wl0 + k] : -1, 4);
            check("t3_oe_before_wr", (pre0 + k < oe_pre_q.size()) ? 32'(oe_pre_q[pre0 + k]) : 0, 1);
            check("t3_oe_after_wr", (post0 + k < oe_post_q.size()) ? 32'(oe_post_q[post0 + k]) : 0, 1);
        end

        // TX overflow: chip not ready, 17 pushes
        ft_txe_n = 1'b1;
        repeat (6) tick();
        cap0 = tx_cap_q.size();
        for (int k = 1; k <= 17; k++) begin
            b = 8'($urandom_range(0, 255));
            tx_req = 1'b1; tx_data = b;
            tick();
            check("t4_tx_full", tx_full, 32'(k >= 15));
            check("t4_tx_drop", tx_drop, 32'(k == 17));
            if (k <= 16) exp_tx.push_back(b);
        end
        tx_req = 1'b0;
        tick();
        check("t4_drop_once", tx_drop, 0);
        ft_txe_n = 1'b0;
        wait_caps(cap0, 16, "t4_capture_count");
        check_caps(cap0, 16, "t4_tx_byte");
        check("t4_full_cleared", tx_full, 0);

        // Arbitration: both directions ready at the same edge
        ft_txe_n = 1'b1;
        repeat (6) tick();
        for (int k = 0; k < 6; k++) push_tx(8'($urandom_range(0, 255)));
        d0 = dir_q.size(); cap0 = tx_cap_q.size();
        for (int k = 0; k < 6; k++) send_rx(8'($urandom_range(0, 255)));
        tick();
        ft_txe_n = 1'b0;
        for (int i = 0; i < 400 && dir_q.size() - d0 < 12; i++) tick();
        repeat (4) tick();
        for (int k = 0; k < 12; k++)
            check("t5_direction", (d0 + k < dir_q.size()) ? dir_q[d0 + k] : 0, (k % 2 == 0) ? 1 : 2);
        check_caps(cap0, 6, "t5_tx_byte");
        for (int k = 0; k < 6; k++) pop_check("t5_rx_byte");
        repeat (3) tick();
        check("t5_rx_empty", rx_empty, 1);
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        check("t5_underrun", rx_underrun, 1);
        check("t5_rx_data_held", rx_data, last_rx);
        tick();
        check("t5_underrun_once", rx_underrun, 0);

        // Reset in the middle of a write pulse
        ft_txe_n = 1'b1;
        repeat (4) tick();
        send_rx(8'($urandom_range(0, 255)));
        for (int i = 0; i < 100 && chip_rd < chip_wr; i++) tick();
        repeat (2) tick();
        push_tx(8'($urandom_range(0, 255)));
        ft_txe_n = 1'b0;
        for (int i = 0; i < 60 && wr_n !== 1'b0; i++) tick();
        check("t6_in_wr_low", wr_n, 0);
        tick();
        check("t6_rx_has_byte", rx_empty, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_wr_n", wr_n, 1);
        check("t6_rst_oe", oe, 0);
        check("t6_rst_rx_empty", rx_empty, 1);
        check("t6_rst_ft_data", ft_dout, 0);
        ft_txe_n = 1'b1;
        exp_rx.delete();
        exp_tx.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_n !== 1'b1 || wr_n !== 1'b1 || oe !== 1'b0) bad++;
        end
        check("t6_no_spurious_strobe", bad, 0);
        check("t6_tx_full_after", tx_full, 0);
        cap0 = tx_cap_q.size();
        push_tx(8'($urandom_range(0, 255)));
        ft_txe_n = 1'b0;
        wait_caps(cap0, 1, "t6_capture_after_reset");
        check_caps(cap0, 1, "t6_tx_byte_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
